// File: rtl/bcd_step_counter_pkg.sv
// Shared constants and types for the two-digit BCD step counter.
// Both the digit cells and the top import this package.
package bcd_step_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic is_bcd(input logic [3:0] nib);
    return nib <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (0-9) with load, increment and decrement.
// Load wins over inc/dec. The wrap outputs ripple into the next digit.
module bcd_digit
  import bcd_step_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       wrap_up,
  output logic       wrap_dn
);

  bcd_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= BCD_ZERO;
    end else if (load) begin
      // Out-of-range nibbles load as zero so the digit never leaves BCD.
      r_q <= is_bcd(load_val) ? load_val : BCD_ZERO;
    end else if (inc) begin
      r_q <= (r_q == BCD_MAX) ? BCD_ZERO : r_q + 4'd1;
    end else if (dec) begin
      r_q <= (r_q == BCD_ZERO) ? BCD_MAX : r_q - 4'd1;
    end
  end

  assign q       = r_q;
  assign wrap_up = inc & ~load & (r_q == BCD_MAX);
  assign wrap_dn = dec & ~load & (r_q == BCD_ZERO);

endmodule

// File: rtl/bcd_step_counter.sv
// Two-digit BCD up/down counter stepped by a debounced pushbutton.
// Priority per cycle: rst > load > (step & en). Pulses are registered.
module bcd_step_counter
  import bcd_step_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       step_btn,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       borrow,
  output logic       load_err
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       r_s1;
  logic       r_s2;
  logic       r_clean;
  logic       r_clean_d;
  logic [7:0] r_db_cnt;
  logic       r_carry;
  logic       r_borrow;
  logic       r_load_err;

  logic       w_step;
  logic       w_step_go;
  logic       w_inc;
  logic       w_dec;
  logic       w_ones_wrap_up;
  logic       w_ones_wrap_dn;
  logic       w_tens_wrap_up;
  logic       w_tens_wrap_dn;
  logic       w_load_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_clean   <= 1'b0;
      r_clean_d <= 1'b0;
      r_db_cnt  <= 8'd0;
    end else begin
      r_s1      <= step_btn;
      r_s2      <= r_s1;
      r_clean_d <= r_clean;
      // Any sample matching the clean level restarts the qualification window.
      if (r_s2 == r_clean) begin
        r_db_cnt <= 8'd0;
      end else if (r_db_cnt == DB_LAST) begin
        r_clean  <= r_s2;
        r_db_cnt <= 8'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 8'd1;
      end
    end
  end

  // Press edge only; a release never steps the count.
  assign w_step     = r_clean & ~r_clean_d;
  assign w_step_go  = w_step & en & ~load;
  assign w_inc      = w_step_go & (up == DIR_UP);
  assign w_dec      = w_step_go & (up != DIR_UP);
  assign w_load_bad = load & (~is_bcd(load_val[7:4]) | ~is_bcd(load_val[3:0]));

  bcd_digit u_ones (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_inc),
    .dec      (w_dec),
    .load     (load),
    .load_val (load_val[3:0]),
    .q        (ones),
    .wrap_up  (w_ones_wrap_up),
    .wrap_dn  (w_ones_wrap_dn)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_ones_wrap_up),
    .dec      (w_ones_wrap_dn),
    .load     (load),
    .load_val (load_val[7:4]),
    .q        (tens),
    .wrap_up  (w_tens_wrap_up),
    .wrap_dn  (w_tens_wrap_dn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_carry    <= w_tens_wrap_up;
      r_borrow   <= w_tens_wrap_dn;
      r_load_err <= w_load_bad;
    end
  end

  assign carry    = r_carry;
  assign borrow   = r_borrow;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter at the default debounce depth of 4.
module tb_bcd_step_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       up;
  logic       step_btn;
  logic       load;
  logic [7:0] load_val;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       carry;
  logic       borrow;
  logic       load_err;

  int checks   = 0;
  int failures = 0;

  bcd_step_counter #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .step_btn (step_btn),
    .load     (load),
    .load_val (load_val),
    .ones     (ones),
    .tens     (tens),
    .carry    (carry),
    .borrow   (borrow),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the button 10 cycles, release 10 cycles, counting output pulses.
  task automatic press(input logic dir, output int n_carry, output int n_borrow, output int n_lerr);
    n_carry = 0; n_borrow = 0; n_lerr = 0;
    up = dir;
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) step_btn = 1'b0;
      tick();
      n_carry  += int'(carry);
      n_borrow += int'(borrow);
      n_lerr   += int'(load_err);
    end
  endtask

  task automatic do_load(input logic [7:0] val);
    load = 1'b1;
    load_val = val;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; up = 1'b1; step_btn = 1'b0; load = 1'b0; load_val = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({tens, ones, carry, borrow, load_err} !== 11'h000) begin
      failures++;
      $display("FAIL reset: tens=%0d ones=%0d c=%b b=%b le=%b want all 0", tens, ones, carry, borrow, load_err);
    end
  endtask

  task automatic test_latency();
    int nc, nb, nl;
    step_btn = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (ones !== ((k >= 7) ? 4'd1 : 4'd0) || tens !== 4'd0) begin
        failures++;
        $display("FAIL latency edge %0d: tens=%0d ones=%0d want 0/%0d", k, tens, ones, (k >= 7) ? 1 : 0);
      end
    end
    step_btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (ones !== 4'd1) begin
      failures++;
      $display("FAIL release_no_step: ones=%0d want 1", ones);
    end
    press(1'b1, nc, nb, nl);
    checks++;
    if (ones !== 4'd2 || tens !== 4'd0) begin
      failures++;
      $display("FAIL repress: tens=%0d ones=%0d want 0/2", tens, ones);
    end
  endtask

  task automatic test_glitch();
    int n_pulse;
    do_load(8'h00);
    n_pulse = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) step_btn = 1'b0;
      tick();
      n_pulse += int'(carry) + int'(borrow) + int'(load_err);
    end
    checks++;
    if (ones !== 4'd0 || tens !== 4'd0 || n_pulse != 0) begin
      failures++;
      $display("FAIL glitch: tens=%0d ones=%0d pulses=%0d want 0/0/0", tens, ones, n_pulse);
    end
  endtask

  task automatic test_carry();
    int nc, nb, nl;
    do_load(8'h98);
    checks++;
    if (tens !== 4'd9 || ones !== 4'd8 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_98: tens=%0d ones=%0d le=%b want 9/8/0", tens, ones, load_err);
    end
    press(1'b1, nc, nb, nl);
    checks++;
    if (tens !== 4'd9 || ones !== 4'd9 || nc != 0) begin
      failures++;
      $display("FAIL up_to_99: tens=%0d ones=%0d carries=%0d want 9/9/0", tens, ones, nc);
    end
    press(1'b1, nc, nb, nl);
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || nc != 1 || nb != 0) begin
      failures++;
      $display("FAIL wrap_99_00: tens=%0d ones=%0d carries=%0d borrows=%0d want 0/0/1/0", tens, ones, nc, nb);
    end
  endtask

  task automatic test_borrow();
    int nc, nb, nl;
    press(1'b0, nc, nb, nl);
    checks++;
    if (tens !== 4'd9 || ones !== 4'd9 || nb != 1 || nc != 0) begin
      failures++;
      $display("FAIL wrap_00_99: tens=%0d ones=%0d borrows=%0d carries=%0d want 9/9/1/0", tens, ones, nb, nc);
    end
    press(1'b0, nc, nb, nl);
    checks++;
    if (tens !== 4'd9 || ones !== 4'd8 || nb != 0) begin
      failures++;
      $display("FAIL down_99_98: tens=%0d ones=%0d borrows=%0d want 9/8/0", tens, ones, nb);
    end
  endtask

  task automatic test_tens_ripple();
    int nc, nb, nl;
    do_load(8'h39);
    press(1'b1, nc, nb, nl);
    checks++;
    if (tens !== 4'd4 || ones !== 4'd0 || nc != 0) begin
      failures++;
      $display("FAIL up_39_40: tens=%0d ones=%0d carries=%0d want 4/0/0", tens, ones, nc);
    end
    press(1'b0, nc, nb, nl);
    checks++;
    if (tens !== 4'd3 || ones !== 4'd9 || nb != 0) begin
      failures++;
      $display("FAIL down_40_39: tens=%0d ones=%0d borrows=%0d want 3/9/0", tens, ones, nb);
    end
  endtask

  task automatic test_load_err();
    do_load(8'hA5);
    checks++;
    if (tens !== 4'd0 || ones !== 4'd5 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL load_A5: tens=%0d ones=%0d le=%b want 0/5/1", tens, ones, load_err);
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse: le=%b want 0", load_err);
    end
    do_load(8'h3F);
    checks++;
    if (tens !== 4'd3 || ones !== 4'd0 || load_err !== 1'b1) begin
      failures++;
      $display("FAIL load_3F: tens=%0d ones=%0d le=%b want 3/0/1", tens, ones, load_err);
    end
    tick();
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("FAIL load_err_pulse2: le=%b want 0", load_err);
    end
  endtask

  task automatic test_load_beats_step();
    // Press lands on edge 7 from the first sample; load occupies that edge.
    do_load(8'h20);
    up = 1'b1;
    step_btn = 1'b1;
    repeat (6) tick();
    load = 1'b1;
    load_val = 8'h61;
    tick();
    load = 1'b0;
    repeat (4) tick();
    step_btn = 1'b0;
    repeat (10) tick();
    checks++;
    if (tens !== 4'd6 || ones !== 4'd1 || carry !== 1'b0) begin
      failures++;
      $display("FAIL load_over_step: tens=%0d ones=%0d want 6/1", tens, ones);
    end
  endtask

  task automatic test_reset_priority();
    int n_pulse;
    do_load(8'h17);
    rst = 1'b1;
    load = 1'b1;
    load_val = 8'hA2;
    tick();
    rst = 1'b0;
    load = 1'b0;
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_over_load: tens=%0d ones=%0d le=%b want 0/0/0", tens, ones, load_err);
    end
    do_load(8'h42);
    step_btn = 1'b1;
    up = 1'b1;
    repeat (5) tick();
    // Without reset, the next edge would qualify the press.
    rst = 1'b1;
    step_btn = 1'b0;
    tick();
    rst = 1'b0;
    n_pulse = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_pulse += int'(carry) + int'(borrow) + int'(load_err);
    end
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || n_pulse != 0) begin
      failures++;
      $display("FAIL rst_mid_debounce: tens=%0d ones=%0d pulses=%0d want 0/0/0", tens, ones, n_pulse);
    end
  endtask

  task automatic test_enable_off();
    int nc, nb, nl;
    do_load(8'h99);
    en = 1'b0;
    press(1'b1, nc, nb, nl);
    checks++;
    if (tens !== 4'd9 || ones !== 4'd9 || nc != 0 || nb != 0) begin
      failures++;
      $display("FAIL en_off: tens=%0d ones=%0d carries=%0d want 9/9/0", tens, ones, nc);
    end
    en = 1'b1;
    press(1'b1, nc, nb, nl);
    checks++;
    if (tens !== 4'd0 || ones !== 4'd0 || nc != 1) begin
      failures++;
      $display("FAIL en_back_on: tens=%0d ones=%0d carries=%0d want 0/0/1", tens, ones, nc);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_carry();
    test_borrow();
    test_tens_ripple();
    test_load_err();
    test_load_beats_step();
    test_reset_priority();
    test_enable_off();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
